// File: rtl/audio_pkg.sv
// audio_pkg
// Shared definitions for the audio playback path: memory geometry of the
// 128K x 16 sample memory and the player state encoding.
package audio_pkg;

    localparam int ADDR_W    = 17;
    localparam int DATA_W    = 16;
    localparam int MEM_DEPTH = 131072;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } player_state_e;

endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo
// Synchronous show-ahead FIFO. The head entry is visible on head_o whenever
// the FIFO is not empty. When empty, head_o is 0.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset (control only)
//   push_i         write push_data_i (ignored when full or flushing)
//   push_data_i    data to write
//   pop_i          drop the head entry (ignored when empty or flushing)
//   flush_i        empty the FIFO at the next edge; wins over push/pop
//   head_o         current head entry
//   count_o        number of stored entries
//   empty_o/full_o occupancy flags
module audio_sample_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [DATA_W-1:0]          head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    always_comb begin
        empty_o  = (count_q == '0);
        full_o   = (count_q == CNT_W'(DEPTH));
        do_push  = push_i && !full_o && !flush_i;
        do_pop   = pop_i && !empty_o && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        // Gate the head so the output is a clean 0 when nothing is stored.
        head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
        count_o = count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/audio_memory_player.sv
// audio_memory_player
// Playback sequencer for the audio sample memory. Reads a programmable,
// inclusive address window one word per cycle, buffers returned samples in
// a small FIFO and streams them out as an Avalon-ST source.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, stop             one-cycle control pulses
//   loop_en                 wrap to start_addr after end_addr
//   start_addr, end_addr    window bounds, captured when start is accepted
//   mem_address,
//   mem_chipselect          memory read request
//   mem_readdata            memory data, READ_LATENCY cycles after request
//   src_data, src_valid,
//   src_ready               sample stream toward the codec
//   busy                    player not idle
//   done                    one-cycle pulse when a one-shot window finishes
module audio_memory_player #(
    parameter int ADDR_W       = audio_pkg::ADDR_W,
    parameter int DATA_W       = audio_pkg::DATA_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              busy,
    output logic              done
);
    import audio_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IFL_W = $clog2(READ_LATENCY + 1);
    localparam int CRD_W = CNT_W + 1;

    player_state_e           state_q, state_d;
    logic [ADDR_W-1:0]       ptr_q, ptr_d;
    logic [ADDR_W-1:0]       start_q, end_q;
    logic [READ_LATENCY-1:0] infl_q, infl_d;
    logic [IFL_W-1:0]        infl_cnt;
    logic [CRD_W-1:0]        credit_used;
    logic [CNT_W-1:0]        fifo_count;
    logic [DATA_W-1:0]       fifo_head;
    logic                    fifo_empty, fifo_full;
    logic                    fifo_push, fifo_pop, fifo_flush;
    logic                    issue, stop_acc, load, done_c;

    function automatic logic [IFL_W-1:0] count_ones(input logic [READ_LATENCY-1:0] v);
        logic [IFL_W-1:0] n;
        n = '0;
        for (int i = 0; i < READ_LATENCY; i++) n = n + IFL_W'(v[i]);
        return n;
    endfunction

    always_comb begin
        infl_cnt    = count_ones(infl_q);
        // Every outstanding read already owns a FIFO slot, so the FIFO can
        // never overflow and the memory needs no stall signal.
        credit_used = CRD_W'(infl_cnt) + CRD_W'(fifo_count);
        stop_acc    = stop && ((state_q == RUN) || (state_q == DRAIN));
        issue       = (state_q == RUN) && !stop && !fifo_full &&
                      (credit_used < CRD_W'(FIFO_DEPTH));
        // Flush on the stop cycle itself so src_valid drops on the next cycle.
        fifo_flush  = stop_acc || (state_q == FLUSH);
        fifo_push   = infl_q[READ_LATENCY-1] && !fifo_flush;
        fifo_pop    = !fifo_empty && src_ready;

        infl_d[0] = issue;
        for (int i = 1; i < READ_LATENCY; i++) infl_d[i] = infl_q[i-1];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        load    = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    ptr_d   = start_addr;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = FLUSH;
                end else if (issue) begin
                    if (ptr_q == end_q) begin
                        if (loop_en) ptr_d = start_q;
                        else         state_d = DRAIN;
                    end else begin
                        // Modulo 2^ADDR_W, so windows may wrap through 0.
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (stop) begin
                    state_d = FLUSH;
                end else if ((infl_cnt == '0) && fifo_empty) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (infl_cnt == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            infl_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            infl_q  <= infl_d;
        end
    end

    // Window bounds are only meaningful after an accepted start.
    always_ff @(posedge clk) begin
        if (load) begin
            start_q <= start_addr;
            end_q   <= end_addr;
        end
    end

    audio_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (fifo_push),
        .push_data_i (mem_readdata),
        .pop_i       (fifo_pop),
        .flush_i     (fifo_flush),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign mem_address    = ptr_q;
    assign mem_chipselect = issue;
    assign src_valid      = !fifo_empty;
    assign src_data       = fifo_head;
    assign busy           = (state_q != IDLE);
    assign done           = done_c;

endmodule
